// File: rtl/led_line_shifter.sv
// Line-load responder for the LED matrix.
// Fetches one line of pixel pairs and shifts thresholded RGB into the panel.
module led_line_shifter #(
  parameter int COLS  = 64,
  parameter int COL_W = 6,
  parameter int ROW_W = 5
) (
  input  logic                   clk_25MHz,
  input  logic                   reset,
  input  logic                   line_begin,
  input  logic [ROW_W-1:0]       line_addr,
  input  logic [3:0]             line_pwm,
  output logic                   line_done,
  output logic                   busy,
  output logic                   ram_rd,
  output logic [ROW_W+COL_W-1:0] ram_addr,
  input  logic [23:0]            ram_data,
  output logic [2:0]             rgb_top,
  output logic [2:0]             rgb_bot,
  output logic                   sclk
);

  typedef enum logic [2:0] {
    IDLE,
    S_ADDR,
    S_DATA,
    S_CLK,
    S_DONE
  } state_t;

  localparam logic [COL_W-1:0] LAST = COL_W'(COLS - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [3:0]       pwm;

  function automatic logic [2:0] lit(
    input logic [11:0] px,
    input logic [3:0]  th
  );
    return {px[11:8] > th, px[7:4] > th, px[3:0] > th};
  endfunction

  // Outputs are loaded on entry to each state so they are valid for the
  // whole state cycle; ram_data is valid by the end of the S_ADDR cycle.
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      pwm       <= '0;
      line_done <= 1'b0;
      busy      <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      rgb_top   <= '0;
      rgb_bot   <= '0;
      sclk      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (line_begin) begin
            row      <= line_addr;
            pwm      <= line_pwm;
            col      <= '0;
            ram_addr <= {line_addr, {COL_W{1'b0}}};
            ram_rd   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          ram_rd  <= 1'b0;
          rgb_top <= lit(ram_data[23:12], pwm);
          rgb_bot <= lit(ram_data[11:0], pwm);
          state   <= S_DATA;
        end
        S_DATA: begin
          sclk  <= 1'b1;
          state <= S_CLK;
        end
        S_CLK: begin
          sclk <= 1'b0;
          if (col == LAST) begin
            line_done <= 1'b1;
            state     <= S_DONE;
          end else begin
            col      <= col + COL_W'(1);
            ram_addr <= {row, col + COL_W'(1)};
            ram_rd   <= 1'b1;
            state    <= S_ADDR;
          end
        end
        S_DONE: begin
          line_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/led_line_shifter.md
Name: led_line_shifter

Overview:
- Responder side of the line-load handshake issued by the matrix row/PWM sequencer.
- On a line-begin pulse, it latches the requested row address and PWM threshold, then reads one line of pixel pairs from the framebuffer RAM.
- Each pixel pair is compared against the threshold and shifted into the panel's column drivers (top-half and bottom-half RGB plus shift clock).
- When the last column has been clocked, it pulses line-done so the sequencer can blank, latch and advance the row.

Parameters:
- COLS, 64, columns per line; power of two, minimum 2.
- COL_W, 6, column counter width; equals log2(COLS).
- ROW_W, 5, width of the row address.

Ports:
- clk_25MHz  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- line_begin  input  1  one-cycle request to load a line; honoured only in IDLE.
- line_addr  input  ROW_W  row to load; sampled with line_begin.
- line_pwm  input  4  PWM threshold for this line; sampled with line_begin.
- line_done  output  1  one-cycle pulse when the line is fully shifted.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- ram_rd  output  1  framebuffer read strobe.
- ram_addr  output  ROW_W+COL_W  read address {row, col}.
- ram_data  input  24  read data, valid one cycle after ram_rd; [23:12] top pixel, [11:0] bottom pixel, each {R[11:8],G[7:4],B[3:0]} relative.
- rgb_top  output  3  {R,G,B} drive for the top half.
- rgb_bot  output  3  {R,G,B} drive for the bottom half.
- sclk  output  1  panel shift clock; data is captured by the panel on its rising edge.

Behaviour:
- Reset values: state=IDLE; line_done=0, busy=0, ram_rd=0, ram_addr=0, rgb_top=0, rgb_bot=0, sclk=0; column counter=0; latched row and pwm registers=0.
- All outputs are registered. They change only on clk_25MHz edges.
- States: IDLE, S_ADDR, S_DATA, S_CLK, S_DONE.
- IDLE:
  - If line_begin=1: latch line_addr and line_pwm, clear col, go to S_ADDR.
  - Otherwise remain in IDLE.
  - busy=0.
- S_ADDR: ram_addr={row_latched, col}, ram_rd=1, sclk=0, go to S_DATA.
- S_DATA:
  - ram_rd=0. Capture ram_data.
  - Drive each rgb bit as (channel nibble > pwm_latched), unsigned 4-bit compare.
  - sclk=0. Go to S_CLK.
- S_CLK:
  - sclk=1; rgb is held stable.
  - If col==COLS-1, go to S_DONE; otherwise increment col and go to S_ADDR.
- S_DONE: sclk=0, line_done=1 for exactly this cycle, then go to IDLE. rgb holds its last value.
- Timing:
  - 3 cycles per column.
  - line_done is high exactly 3*COLS+1 cycles after the cycle in which line_begin was sampled (193 for COLS=64).
  - sclk produces exactly COLS rising edges per line.
  - rgb is stable for 1 cycle before and during each sclk-high cycle.
- Compare boundaries:
  - Nibble 0 is never lit.
  - pwm=15 lights nothing.
  - pwm=0 lights every nonzero nibble.
  - Nibble equal to pwm is off.
- line_begin outside IDLE (including during S_DONE) is ignored and not queued.
- line_addr and line_pwm changes after acceptance have no effect on the current line.
- Column counter wraps only via the S_CLK→S_DONE path. ram_addr never exceeds {row, COLS-1}.
- Reset mid-line: all outputs return to reset values on the next edge. No line_done is emitted, and any partial line is discarded.
- Simultaneous reset and line_begin: reset wins and the request is dropped.

Test Plan:
- Reset: assert reset 2 cycles with random inputs → all outputs 0, busy=0, no sclk edges.
- Full line, COLS=4:
  - Stimulus: line_begin with line_addr=5, line_pwm=7; RAM returns 0xF80_07F for every column.
  - ram_addr sequence is 0x14,0x15,0x16,0x17.
  - rgb_top=3'b110, rgb_bot=3'b001 at each column.
  - 4 sclk rising edges; line_done high 13 cycles after begin, for 1 cycle.
- Threshold edges:
  - pwm=7: nibble 7→0, nibble 8→1.
  - pwm=15: nibble 15→0.
  - pwm=0: nibble 1→1, nibble 0→0.
- Busy protection: pulse line_begin with addr=9 during column 2 of a line with addr=3 → addresses stay row 3, single line_done, no second line starts.
- Reset mid-line at column 2 → next cycle sclk=0, ram_rd=0, busy=0, no line_done. A following line_begin with addr=1 completes normally in 13 cycles (COLS=4).
- Back-to-back: line_begin one cycle after line_done → accepted. A begin coincident with line_done → ignored.
